ref_buffer_fetch: RTL

- Read-side initiator for the CAF reference buffer: on a start pulse, issues sequential sample-address reads over the buffer's valid/ready read interface.
- Captures the returned I/Q samples and streams them downstream to the correlator through a small credit-managed FIFO.
- Address sweep wraps modulo BUFFER_LENGTH, so any circular window of the reference can be replayed.

---
 rtl/caf_ref_pkg.sv | 26 ++
 rtl/ref_sample_fifo.sv | 62 ++++++
 rtl/ref_buffer_fetch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/caf_ref_pkg.sv
// Shared types for the CAF reference-buffer fetch path: FSM states,
// the buffered sample word and circular address arithmetic.
package caf_ref_pkg;

    localparam int SAMPLE_I_BITS = 12;
    localparam int SAMPLE_Q_BITS = 12;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_e;

    typedef struct packed {
        logic signed [SAMPLE_I_BITS-1:0] i;
        logic signed [SAMPLE_Q_BITS-1:0] q;
        logic                            last;
    } sample_t;

    // Next address in a circular buffer of len entries.
    function automatic int unsigned wrap_inc(int unsigned addr, int unsigned len);
        return (addr + 1 >= len) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/ref_sample_fifo.sv
// Small synchronous sample FIFO; push on full is accepted only when a pop
// frees the head slot in the same cycle.
module ref_sample_fifo
    import caf_ref_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  sample_t          wdata,
    input  logic             pop,
    output sample_t          rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    sample_t          mem_q [DEPTH];
    sample_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = count_q == CNT_W'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ref_buffer_fetch.sv
// Reference-buffer read initiator: sweeps a circular address window and
// streams returned I/Q samples through a credit-managed output FIFO.
module ref_buffer_fetch
    import caf_ref_pkg::*;
#(
    parameter int I_BITS        = SAMPLE_I_BITS,
    parameter int Q_BITS        = SAMPLE_Q_BITS,
    parameter int INDEX_BITS    = 10,
    parameter int BUFFER_LENGTH = 1000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [INDEX_BITS-1:0]    start_addr,
    input  logic [INDEX_BITS:0]      count,
    output logic                     m_axi_rvalid,
    output logic [INDEX_BITS-1:0]    m_axi_raddr,
    input  logic                     s_axi_rready,
    input  logic                     s_axi_rvalid,
    output logic                     m_axi_rready,
    input  logic signed [I_BITS-1:0] i,
    input  logic signed [Q_BITS-1:0] q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [I_BITS-1:0] out_i,
    output logic signed [Q_BITS-1:0] out_q,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LEN_W = INDEX_BITS + 1;

    fetch_state_e          state_q, state_d;
    logic [INDEX_BITS-1:0] raddr_q, raddr_d;
    logic [LEN_W-1:0]      count_q, count_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic [LEN_W-1:0]      returned_q, returned_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  error_q, error_d;

    sample_t          push_word, head_word;
    logic             push, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             credit_ok, addr_hs;

    // A read is only issued when its sample is guaranteed a FIFO slot.
    assign credit_ok = (int'(outstanding_q) + int'(fifo_count)) < FIFO_DEPTH
                       && !fifo_full;

    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign error        = error_q;
    assign m_axi_rready = busy;
    assign m_axi_rvalid = (state_q == FETCH) && (issued_q < count_q) && credit_ok;
    assign m_axi_raddr  = raddr_q;
    assign addr_hs      = m_axi_rvalid && s_axi_rready;
    assign push         = m_axi_rready && s_axi_rvalid;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_i     = out_valid ? head_word.i : '0;
    assign out_q     = out_valid ? head_word.q : '0;
    assign out_last  = out_valid && head_word.last;

    always_comb begin
        push_word.i    = i;
        push_word.q    = q;
        push_word.last = (returned_q + LEN_W'(1)) == count_q;
    end

    ref_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head_word),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        raddr_d       = raddr_q;
        count_d       = count_q;
        issued_d      = issued_q;
        returned_d    = returned_q;
        error_d       = 1'b0;
        outstanding_d = outstanding_q + CNT_W'(addr_hs) - CNT_W'(push);

        if (addr_hs) begin
            raddr_d  = INDEX_BITS'(wrap_inc(32'(raddr_q), BUFFER_LENGTH));
            issued_d = issued_q + LEN_W'(1);
        end
        if (push) begin
            returned_d = returned_q + LEN_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (int'(start_addr) >= BUFFER_LENGTH) begin
                        error_d = 1'b1;
                    end else if (count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = FETCH;
                        raddr_d    = start_addr;
                        count_d    = count;
                        issued_d   = '0;
                        returned_d = '0;
                    end
                end
            end
            FETCH: begin
                if (addr_hs && (issued_q + LEN_W'(1)) == count_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Popping the tagged word means nothing else is buffered or in flight.
                if (pop && head_word.last && outstanding_q == '0
                    && fifo_count == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            raddr_q       <= '0;
            count_q       <= '0;
            issued_q      <= '0;
            returned_q    <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            raddr_q       <= raddr_d;
            count_q       <= count_d;
            issued_q      <= issued_d;
            returned_q    <= returned_d;
            outstanding_q <= outstanding_d;
            error_q       <= error_d;
        end
    end

endmodule
